// File: rtl/canny_accel_hls_deadlock_monitor_if.sv
// Bundle between one dataflow process's deadlock monitor and its surroundings:
// dependence channels, report token ring, detect flags and the blocked-channel report.
interface canny_accel_hls_deadlock_monitor_if #(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned IN_CHAN_NUM  = 2,
  parameter int unsigned OUT_CHAN_NUM = 3,
  parameter int unsigned CNT_W        = 16
);
  localparam int unsigned IDX_W = (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;

  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]          token_in_vec;
  logic                            dl_detect_in;
  logic                            origin;
  logic                            token_clear;
  logic                            rpt_ready;

  logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]             out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]         token_out_vec;
  logic                            dl_detect_out;
  logic                            dl_confirmed;
  logic                            rpt_valid;
  logic [IDX_W-1:0]                rpt_chan_idx;
  logic [CNT_W-1:0]                stall_cnt;

  // Monitor side
  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear, rpt_ready,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
           dl_confirmed, rpt_valid, rpt_chan_idx, stall_cnt
  );

  // Dataflow region / report consumer side
  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear, rpt_ready,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
           dl_confirmed, rpt_valid, rpt_chan_idx, stall_cnt
  );
endinterface

// File: rtl/canny_accel_hls_deadlock_monitor.sv
// Per-process deadlock monitor: propagates dependence vectors along blocked channels,
// confirms a dependence cycle only after it persists, then reports the blocked output
// channels one index at a time and forwards the report token.
module canny_accel_hls_deadlock_monitor #(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned CNT_W          = 16
) (
  input logic                              clock,
  input logic                              reset,
  canny_accel_hls_deadlock_monitor_if.slave bus
);
  localparam int unsigned IDX_W = (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;
  localparam int unsigned CW    = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StConfirm, StReport, StHold} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [OUT_CHAN_NUM-1:0] pend_q;
  logic                    dl_detect_q;
  logic [PROC_NUM-1:0]     dep_reg_q;
  logic [OUT_CHAN_NUM-1:0] token_out_q;
  logic [CNT_W-1:0]        stall_q;

  logic [PROC_NUM-1:0]     dep_in;
  logic [PROC_NUM-1:0]     dep;
  logic                    gate;
  logic                    blocked;
  logic                    raw;
  logic                    cnt_hit;
  logic                    rpt_fire;
  logic [IDX_W-1:0]        low_idx;
  logic [OUT_CHAN_NUM-1:0] pend_after;

  assign blocked = |bus.proc_dep_vld_vec;
  // A globally detected deadlock freezes propagation unless the token is passing through.
  assign gate    = ~bus.dl_detect_in | (|bus.token_in_vec);
  assign dep     = gate ? dep_in : dep_reg_q;
  assign raw     = gate & dep[PROC_ID] & blocked;
  assign cnt_hit = (32'(cnt_q) + 32'd1) == CONFIRM_CYCLES;

  // Merge the dependence vectors of all valid incoming channels.
  always_comb begin
    dep_in = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      dep_in |= {PROC_NUM{bus.in_chan_dep_vld_vec[i]}} &
                bus.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // Pick the lowest pending blocked channel.
  always_comb begin
    low_idx = '0;
    for (int k = OUT_CHAN_NUM - 1; k >= 0; k--) begin
      if (pend_q[k]) low_idx = IDX_W'(k);
    end
  end

  assign pend_after = pend_q & ~(OUT_CHAN_NUM'(1) << low_idx);
  assign rpt_fire   = bus.rpt_valid & bus.rpt_ready;

  // Confirmation / report FSM; token_clear beats every other event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= '0;
      dl_detect_q <= 1'b0;
    end else begin
      dl_detect_q <= 1'b0;
      if (bus.token_clear) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        pend_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (raw) begin
              if (CONFIRM_CYCLES == 1) begin
                state_q     <= StReport;
                pend_q      <= bus.proc_dep_vld_vec;
                dl_detect_q <= 1'b1;
              end else begin
                state_q <= StConfirm;
                cnt_q   <= CW'(1);
              end
            end
          end
          StConfirm: begin
            if (!raw) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_hit) begin
              state_q     <= StReport;
              cnt_q       <= '0;
              pend_q      <= bus.proc_dep_vld_vec;
              dl_detect_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StReport: begin
            if (rpt_fire) begin
              pend_q <= pend_after;
              if (pend_after == '0) state_q <= StHold;
            end else if (pend_q == '0) begin
              state_q <= StHold;
            end
          end
          StHold:  state_q <= StHold;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Dependence register, token forwarding and saturating stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dep_reg_q   <= '0;
      token_out_q <= '0;
      stall_q     <= '0;
    end else begin
      dep_reg_q   <= blocked ? dep : '0;
      token_out_q <= (((|bus.token_in_vec) & ~bus.token_clear) | bus.origin) ?
                     bus.proc_dep_vld_vec : '0;
      if (bus.token_clear || !blocked) begin
        stall_q <= '0;
      end else if (stall_q != CntMax) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
  assign bus.out_chan_dep_data    = dep_reg_q | (PROC_NUM'(1) << PROC_ID);
  assign bus.token_out_vec        = token_out_q;
  assign bus.dl_detect_out        = dl_detect_q;
  assign bus.dl_confirmed         = (state_q == StReport) || (state_q == StHold);
  assign bus.rpt_valid            = (state_q == StReport) && (pend_q != '0);
  assign bus.rpt_chan_idx         = (state_q == StReport) ? low_idx : '0;
  assign bus.stall_cnt            = stall_q;
endmodule

// File: tb/tb_canny_accel_hls_deadlock_monitor.sv
// Bench for the deadlock monitor: directed stimulus, a behavioural model checked every
// cycle, plus hand-computed literal checks at the key moments.
module tb_canny_accel_hls_deadlock_monitor;
  localparam int unsigned PN = 4, PID = 1, INN = 2, OUTN = 3, CONF = 4, CW = 3;
  localparam int STALL_MAX = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  canny_accel_hls_deadlock_monitor_if #(
    .PROC_NUM(PN), .IN_CHAN_NUM(INN), .OUT_CHAN_NUM(OUTN), .CNT_W(CW)
  ) bus ();

  canny_accel_hls_deadlock_monitor #(
    .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(INN), .OUT_CHAN_NUM(OUTN),
    .CONFIRM_CYCLES(CONF), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run length of consecutive raw cycles, mode 0 idle/counting, 1 reporting, 2 holding.
  logic [PN-1:0]   m_dep_reg = '0;
  logic [OUTN-1:0] m_token_out = '0;
  int              m_stall = 0;
  int              m_run = 0;
  int              m_mode = 0;
  bit              m_pulse = 1'b0;
  int              m_pend[$];
  logic [PN-1:0]   md_dep;
  logic [OUTN-1:0] md_pv;
  bit              md_gate, md_raw;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_dep_reg = '0; m_token_out = '0; m_stall = 0; m_run = 0; m_mode = 0; m_pulse = 1'b0;
      m_pend.delete();
    end else begin
      md_pv   = bus.proc_dep_vld_vec;
      md_gate = !bus.dl_detect_in || (bus.token_in_vec != 0);
      md_dep  = m_dep_reg;
      if (md_gate) begin
        md_dep = '0;
        for (int i = 0; i < INN; i++)
          if (bus.in_chan_dep_vld_vec[i]) md_dep |= bus.in_chan_dep_data_vec[i*PN +: PN];
      end
      md_raw  = md_gate && md_dep[PID] && (md_pv != 0);
      m_pulse = 1'b0;
      if (bus.token_clear) begin
        m_mode = 0; m_run = 0; m_pend.delete();
      end else if (m_mode == 0) begin
        if (md_raw) begin
          m_run++;
          if (m_run == CONF) begin
            m_mode = 1; m_run = 0; m_pulse = 1'b1;
            for (int k = 0; k < OUTN; k++) if (md_pv[k]) m_pend.push_back(k);
          end
        end else begin
          m_run = 0;
        end
      end else if (m_mode == 1) begin
        if (bus.rpt_ready && m_pend.size() > 0) void'(m_pend.pop_front());
        if (m_pend.size() == 0) m_mode = 2;
      end
      m_token_out = (((bus.token_in_vec != 0) && !bus.token_clear) || bus.origin) ? md_pv : '0;
      if (bus.token_clear || md_pv == 0) m_stall = 0;
      else if (m_stall < STALL_MAX) m_stall++;
      m_dep_reg = (md_pv != 0) ? md_dep : '0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      check("cmp_vld_pass", 32'(bus.out_chan_dep_vld_vec), 32'(bus.proc_dep_vld_vec));
      check("cmp_dep_data", 32'(bus.out_chan_dep_data), 32'(m_dep_reg | (PN'(1) << PID)));
      check("cmp_token_out", 32'(bus.token_out_vec), 32'(m_token_out));
      check("cmp_detect", 32'(bus.dl_detect_out), 32'(m_pulse));
      check("cmp_confirmed", 32'(bus.dl_confirmed), 32'(m_mode != 0));
      check("cmp_rpt_valid", 32'(bus.rpt_valid), 32'(m_mode == 1 && m_pend.size() > 0));
      check("cmp_rpt_idx", 32'(bus.rpt_chan_idx),
            (m_mode == 1 && m_pend.size() > 0) ? 32'(m_pend[0]) : 32'd0);
      check("cmp_stall", 32'(bus.stall_cnt), 32'(m_stall));
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bus.proc_dep_vld_vec = '0; bus.in_chan_dep_vld_vec = '0; bus.in_chan_dep_data_vec = '0;
    bus.token_in_vec = '0; bus.dl_detect_in = 1'b0; bus.origin = 1'b0;
    bus.token_clear = 1'b0; bus.rpt_ready = 1'b0;
    #2 reset = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rst_confirmed", 32'(bus.dl_confirmed), 0);
    check("rst_stall", 32'(bus.stall_cnt), 0);
    check("rst_token", 32'(bus.token_out_vec), 0);
    check("rst_valid", 32'(bus.rpt_valid), 0);

    // Persistent cycle: ch0 carries this process's own bit, blocked on channels 0 and 2.
    next_cycle();
    bus.proc_dep_vld_vec = 3'b101; bus.in_chan_dep_vld_vec = 2'b01;
    bus.in_chan_dep_data_vec = 8'h02;
    repeat (3) begin
      edge_sample();
      check("no_early_detect", 32'(bus.dl_detect_out), 0);
    end
    edge_sample();
    check("detect_5th_cycle", 32'(bus.dl_detect_out), 1);
    check("confirmed_5th", 32'(bus.dl_confirmed), 1);
    check("first_idx", 32'(bus.rpt_chan_idx), 0);
    check("stall_4", 32'(bus.stall_cnt), 4);
    repeat (3) begin
      edge_sample();
      check("idx_stable", 32'(bus.rpt_chan_idx), 0);
      check("valid_stable", 32'(bus.rpt_valid), 1);
      check("single_pulse", 32'(bus.dl_detect_out), 0);
    end
    next_cycle();
    bus.rpt_ready = 1'b1;
    edge_sample();
    check("second_idx", 32'(bus.rpt_chan_idx), 2);
    edge_sample();
    check("hold_no_valid", 32'(bus.rpt_valid), 0);
    check("hold_confirmed", 32'(bus.dl_confirmed), 1);
    check("stall_sat", 32'(bus.stall_cnt), 7);

    // Clear out of HOLD, then confirm again and clear during REPORT with rpt_ready high.
    next_cycle();
    bus.token_clear = 1'b1;
    next_cycle();
    bus.token_clear = 1'b0; bus.rpt_ready = 1'b0;
    @(negedge clock);
    check("clr_hold_conf", 32'(bus.dl_confirmed), 0);
    check("clr_hold_stall", 32'(bus.stall_cnt), 0);
    repeat (3) edge_sample();
    edge_sample();
    check("redetect", 32'(bus.dl_detect_out), 1);
    next_cycle();
    bus.token_clear = 1'b1; bus.rpt_ready = 1'b1;
    next_cycle();
    bus.token_clear = 1'b0; bus.rpt_ready = 1'b0; bus.proc_dep_vld_vec = 3'b000;
    @(negedge clock);
    check("clr_rpt_valid", 32'(bus.rpt_valid), 0);
    check("clr_rpt_conf", 32'(bus.dl_confirmed), 0);
    check("clr_rpt_stall", 32'(bus.stall_cnt), 0);

    // Three raw cycles, one gap, then four fresh ones are required.
    next_cycle();
    bus.proc_dep_vld_vec = 3'b101;
    repeat (3) next_cycle();
    bus.in_chan_dep_vld_vec = 2'b00;
    next_cycle();
    bus.in_chan_dep_vld_vec = 2'b01;
    repeat (3) edge_sample();
    check("gap_no_detect", 32'(bus.dl_confirmed), 0);
    edge_sample();
    check("gap_fresh_detect", 32'(bus.dl_detect_out), 1);

    // Global detect without token: dep frozen at 4'b0010 despite new channel data.
    next_cycle();
    bus.token_clear = 1'b1; bus.dl_detect_in = 1'b1; bus.in_chan_dep_data_vec = 8'h08;
    next_cycle();
    bus.token_clear = 1'b0;
    repeat (4) edge_sample();
    check("frozen_no_conf", 32'(bus.dl_confirmed), 0);
    check("frozen_dep", 32'(bus.out_chan_dep_data), 32'h2);
    next_cycle();
    bus.token_in_vec = 2'b01;
    edge_sample();
    check("token_fwd", 32'(bus.token_out_vec), 32'h5);
    check("token_dep", 32'(bus.out_chan_dep_data), 32'ha);
    next_cycle();
    bus.token_clear = 1'b1;
    edge_sample();
    check("token_clr_blk", 32'(bus.token_out_vec), 0);
    next_cycle();
    bus.token_clear = 1'b0; bus.token_in_vec = 2'b00; bus.origin = 1'b1;
    edge_sample();
    check("origin_fwd", 32'(bus.token_out_vec), 32'h5);

    // Reach REPORT again, then assert reset between edges.
    next_cycle();
    bus.dl_detect_in = 1'b0; bus.in_chan_dep_data_vec = 8'h02;
    repeat (4) edge_sample();
    check("pre_reset_conf", 32'(bus.dl_confirmed), 1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async_conf", 32'(bus.dl_confirmed), 0);
    check("async_valid", 32'(bus.rpt_valid), 0);
    check("async_stall", 32'(bus.stall_cnt), 0);
    check("async_token", 32'(bus.token_out_vec), 0);
    check("async_dep", 32'(bus.out_chan_dep_data), 32'h2);
    repeat (2) next_cycle();
    reset = 1'b0;
    repeat (3) next_cycle();
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
